// File: rtl/acum_mch.sv
// Multi-channel running accumulator: NB_CH independent NB_ACC-bit sums with sticky
// overflow, read out and cleared by a one-cycle-latency dump. Define ACUM_SAT_EN for saturating adds.
module acum_mch #(
  parameter int NB_INPUT = 4,
  parameter int NB_ACC   = 8,
  parameter int NB_CH    = 4,
  parameter int NB_SEL   = 2
) (
  input  logic                e_clk,
  input  logic                e_reset,
  input  logic [NB_INPUT-1:0] e_sum,
  input  logic                e_valid,
  input  logic [NB_SEL-1:0]   e_ch,
  input  logic                e_dump,
  input  logic [NB_SEL-1:0]   e_dch,
  output logic [NB_ACC-1:0]   s_odata,
  output logic                s_ovalid,
  output logic                s_overflow,
  output logic [NB_SEL-1:0]   s_ochan
);

  // Strobe protocol: no backpressure. e_valid / e_dump are accepted on every rising
  // edge they are high; s_ovalid is a one-cycle pulse one edge after each e_dump.

  logic [NB_ACC-1:0] acc [NB_CH];
  logic [NB_CH-1:0]  ovf;
  logic [NB_ACC:0]   sum_w [NB_CH];
  logic [NB_CH-1:0]  samp_hit;
  logic [NB_CH-1:0]  dump_hit;
  logic [NB_ACC-1:0] dump_data;
  logic              dump_ovf;

  // One-hot channel decode; an out-of-range index hits no channel at all.
  for (genvar g = 0; g < NB_CH; g++) begin : g_ch
    assign sum_w[g]    = {1'b0, acc[g]} + {{(NB_ACC + 1 - NB_INPUT){1'b0}}, e_sum};
    assign samp_hit[g] = e_valid && (e_ch == NB_SEL'(g));
    assign dump_hit[g] = e_dump && (e_dch == NB_SEL'(g));
  end

  always_comb begin
    dump_data = '0;
    dump_ovf  = 1'b0;
    for (int i = 0; i < NB_CH; i++) begin
      if (dump_hit[i]) begin
        dump_data = acc[i];
        dump_ovf  = ovf[i];
      end
    end
  end

  always_ff @(posedge e_clk or negedge e_reset) begin
    if (!e_reset) begin
      for (int i = 0; i < NB_CH; i++) begin
        acc[i] <= '0;
      end
      ovf <= '0;
    end else begin
      for (int i = 0; i < NB_CH; i++) begin
        if (dump_hit[i]) begin
          // A same-cycle sample restarts the channel from zero, so it cannot overflow.
          acc[i] <= samp_hit[i] ? {{(NB_ACC - NB_INPUT){1'b0}}, e_sum} : '0;
          ovf[i] <= 1'b0;
        end else if (samp_hit[i]) begin
`ifdef ACUM_SAT_EN
          acc[i] <= sum_w[i][NB_ACC] ? {NB_ACC{1'b1}} : sum_w[i][NB_ACC-1:0];
`else
          acc[i] <= sum_w[i][NB_ACC-1:0];
`endif
          if (sum_w[i][NB_ACC]) begin
            ovf[i] <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge e_clk or negedge e_reset) begin
    if (!e_reset) begin
      s_odata    <= '0;
      s_ovalid   <= 1'b0;
      s_overflow <= 1'b0;
      s_ochan    <= '0;
    end else begin
      s_ovalid <= e_dump;
      if (e_dump) begin
        s_odata    <= dump_data;
        s_overflow <= dump_ovf;
        s_ochan    <= e_dch;
      end
    end
  end

endmodule

// File: tb/tb_acum_mch.sv
// Self-checking bench for acum_mch: directed scenarios plus a randomized run against
// an integer reference model of the channel sums (saturating when ACUM_SAT_EN is defined).
module tb_acum_mch;

  localparam int NB_INPUT = 4;
  localparam int NB_ACC   = 8;
  localparam int NB_CH    = 4;
  localparam int NB_SEL   = 2;
  localparam int ACC_MOD  = 2 ** NB_ACC;

  logic                e_clk;
  logic                e_reset;
  logic [NB_INPUT-1:0] e_sum;
  logic                e_valid;
  logic [NB_SEL-1:0]   e_ch;
  logic                e_dump;
  logic [NB_SEL-1:0]   e_dch;
  logic [NB_ACC-1:0]   s_odata;
  logic                s_ovalid;
  logic                s_overflow;
  logic [NB_SEL-1:0]   s_ochan;

  int total = 0;
  int bad   = 0;

  // reference model: plain integer sums per channel
  int m_acc [NB_CH];
  bit m_ovf [NB_CH];
  logic              exp_valid;
  logic [NB_ACC-1:0] exp_data;
  logic              exp_ovf;
  logic [NB_SEL-1:0] exp_chan;
  logic [NB_ACC-1:0] exp_q[$];

  acum_mch #(
    .NB_INPUT(NB_INPUT),
    .NB_ACC  (NB_ACC),
    .NB_CH   (NB_CH),
    .NB_SEL  (NB_SEL)
  ) dut (
    .e_clk     (e_clk),
    .e_reset   (e_reset),
    .e_sum     (e_sum),
    .e_valid   (e_valid),
    .e_ch      (e_ch),
    .e_dump    (e_dump),
    .e_dch     (e_dch),
    .s_odata   (s_odata),
    .s_ovalid  (s_ovalid),
    .s_overflow(s_overflow),
    .s_ochan   (s_ochan)
  );

  // clock / reset
  initial begin
    e_clk = 1'b0;
    forever #5 e_clk = ~e_clk;
  end

  task automatic model_reset();
    for (int i = 0; i < NB_CH; i++) begin
      m_acc[i] = 0;
      m_ovf[i] = 1'b0;
    end
    exp_valid = 1'b0;
    exp_data  = '0;
    exp_ovf   = 1'b0;
    exp_chan  = '0;
  endtask

  // driver: one clock of stimulus, model updated at the edge, returns 1 time unit after it
  task automatic drive_cycle(input bit v, input int s, input int ch, input bit d, input int dch);
    int t;
    @(negedge e_clk);
    e_valid = v;
    e_sum   = NB_INPUT'(s);
    e_ch    = NB_SEL'(ch);
    e_dump  = d;
    e_dch   = NB_SEL'(dch);
    @(posedge e_clk);
    exp_valid = d;
    if (d) begin
      exp_data    = NB_ACC'(m_acc[dch]);
      exp_ovf     = m_ovf[dch];
      exp_chan    = NB_SEL'(dch);
      m_acc[dch]  = 0;
      m_ovf[dch]  = 1'b0;
    end
    if (v) begin
      t = m_acc[ch] + s;
      if (t >= ACC_MOD) begin
        m_ovf[ch] = 1'b1;
`ifdef ACUM_SAT_EN
        t = ACC_MOD - 1;
`else
        t = t % ACC_MOD;
`endif
      end
      m_acc[ch] = t;
    end
    #1;
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 0, 0, 1'b0, 0);
  endtask

  task automatic test_reset();
    e_reset = 1'b0;
    e_valid = 1'b0; e_sum = '0; e_ch = '0; e_dump = 1'b0; e_dch = '0;
    model_reset();
    repeat (3) @(posedge e_clk);
    #1;
    total++; if (s_ovalid !== 1'b0) begin bad++; $display("FAIL reset_ovalid got=%0b exp=0", s_ovalid); end
    total++; if (s_odata !== '0) begin bad++; $display("FAIL reset_odata got=%0d exp=0", s_odata); end
    total++; if (s_overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b exp=0", s_overflow); end
    total++; if (s_ochan !== '0) begin bad++; $display("FAIL reset_ochan got=%0d exp=0", s_ochan); end
    @(negedge e_clk);
    e_reset = 1'b1;
  endtask

  task automatic test_basic();
    repeat (10) drive_cycle(1'b1, 5, 2, 1'b0, 0);
    drive_cycle(1'b0, 0, 0, 1'b1, 2);
    total++; if (s_ovalid !== 1'b1) begin bad++; $display("FAIL basic_ovalid got=%0b exp=1", s_ovalid); end
    total++; if (s_odata !== exp_data || exp_data !== 8'd50) begin bad++; $display("FAIL basic_odata got=%0d exp=%0d (50)", s_odata, exp_data); end
    total++; if (s_overflow !== 1'b0) begin bad++; $display("FAIL basic_overflow got=%0b exp=0", s_overflow); end
    total++; if (s_ochan !== 2'd2) begin bad++; $display("FAIL basic_ochan got=%0d exp=2", s_ochan); end
    idle_cycle();
    total++; if (s_ovalid !== 1'b0) begin bad++; $display("FAIL basic_pulse_width got=%0b exp=0", s_ovalid); end
    total++; if (s_odata !== 8'd50) begin bad++; $display("FAIL basic_hold got=%0d exp=50", s_odata); end
    drive_cycle(1'b0, 0, 0, 1'b1, 2);
    total++; if (s_ovalid !== 1'b1 || s_odata !== 8'd0) begin bad++; $display("FAIL basic_redump got=%0d/%0b exp=0/1", s_odata, s_ovalid); end
    idle_cycle();
  endtask

  task automatic test_overflow();
    logic [NB_ACC-1:0] want;
`ifdef ACUM_SAT_EN
    want = 8'd255;
`else
    want = 8'd14;
`endif
    repeat (18) drive_cycle(1'b1, 15, 1, 1'b0, 0);
    drive_cycle(1'b0, 0, 0, 1'b1, 1);
    total++; if (s_odata !== want || s_odata !== exp_data) begin bad++; $display("FAIL ovf_odata got=%0d exp=%0d", s_odata, want); end
    total++; if (s_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b exp=1", s_overflow); end
    // sticky flag must be cleared by the dump
    drive_cycle(1'b1, 3, 1, 1'b0, 0);
    drive_cycle(1'b0, 0, 0, 1'b1, 1);
    total++; if (s_overflow !== 1'b0 || s_odata !== 8'd3) begin bad++; $display("FAIL ovf_cleared got=%0d/%0b exp=3/0", s_odata, s_overflow); end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 3, 0, 1'b0, 0);
      drive_cycle(1'b1, 7, 3, 1'b0, 0);
    end
    drive_cycle(1'b0, 0, 0, 1'b1, 0);
    total++; if (s_ovalid !== 1'b1 || s_odata !== 8'd12 || s_ochan !== 2'd0) begin bad++; $display("FAIL b2b_first got=%0d ch=%0d v=%0b exp=12 ch=0 v=1", s_odata, s_ochan, s_ovalid); end
    drive_cycle(1'b0, 0, 0, 1'b1, 3);
    total++; if (s_ovalid !== 1'b1 || s_odata !== 8'd28 || s_ochan !== 2'd3) begin bad++; $display("FAIL b2b_second got=%0d ch=%0d v=%0b exp=28 ch=3 v=1", s_odata, s_ochan, s_ovalid); end
    idle_cycle();
    total++; if (s_ovalid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%0b exp=0", s_ovalid); end
  endtask

  task automatic test_same_cycle();
    repeat (4) drive_cycle(1'b1, 5, 1, 1'b0, 0);
    drive_cycle(1'b1, 9, 1, 1'b1, 1);
    total++; if (s_odata !== 8'd20 || s_ovalid !== 1'b1) begin bad++; $display("FAIL same_pre got=%0d exp=20", s_odata); end
    drive_cycle(1'b0, 0, 0, 1'b1, 1);
    total++; if (s_odata !== 8'd9 || s_overflow !== 1'b0) begin bad++; $display("FAIL same_restart got=%0d/%0b exp=9/0", s_odata, s_overflow); end
    // different channels in the same cycle
    drive_cycle(1'b1, 6, 2, 1'b0, 0);
    drive_cycle(1'b1, 4, 3, 1'b1, 2);
    total++; if (s_odata !== 8'd6 || s_ochan !== 2'd2) begin bad++; $display("FAIL diff_dump got=%0d ch=%0d exp=6 ch=2", s_odata, s_ochan); end
    drive_cycle(1'b0, 0, 0, 1'b1, 3);
    total++; if (s_odata !== 8'd4 || s_ochan !== 2'd3) begin bad++; $display("FAIL diff_sample got=%0d ch=%0d exp=4 ch=3", s_odata, s_ochan); end
    idle_cycle();
  endtask

  task automatic test_random();
    logic [NB_ACC-1:0] want;
    for (int n = 0; n < 400; n++) begin
      drive_cycle(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)), int'($urandom_range(0, NB_CH - 1)),
                  1'($urandom_range(0, 9) == 0), int'($urandom_range(0, NB_CH - 1)));
      if (exp_valid) exp_q.push_back(exp_data);
      total++;
      if (s_ovalid !== exp_valid) begin
        bad++; $display("FAIL rand_ovalid cyc=%0d got=%0b exp=%0b", n, s_ovalid, exp_valid);
      end
      if (s_ovalid === 1'b1 && exp_q.size() > 0) begin
        want = exp_q.pop_front();
        total++;
        if (s_odata !== want || s_overflow !== exp_ovf || s_ochan !== exp_chan) begin
          bad++;
          $display("FAIL rand_dump cyc=%0d got=%0d/%0b/ch%0d exp=%0d/%0b/ch%0d", n, s_odata, s_overflow, s_ochan, want, exp_ovf, exp_chan);
        end
      end
    end
    // drain every channel so the model and the DUT are compared in full
    for (int c = 0; c < NB_CH; c++) begin
      drive_cycle(1'b0, 0, 0, 1'b1, c);
      total++;
      if (s_odata !== exp_data || s_overflow !== exp_ovf) begin
        bad++; $display("FAIL rand_drain ch=%0d got=%0d/%0b exp=%0d/%0b", c, s_odata, s_overflow, exp_data, exp_ovf);
      end
    end
    exp_q.delete();
    idle_cycle();
  endtask

  task automatic test_async_reset();
    repeat (8) drive_cycle(1'b1, 5, 0, 1'b0, 0);
    drive_cycle(1'b1, 7, 3, 1'b0, 0);
    drive_cycle(1'b0, 0, 0, 1'b1, 3);
    total++; if (s_ovalid !== 1'b1 || s_odata !== 8'd7) begin bad++; $display("FAIL areset_pre got=%0d/%0b exp=7/1", s_odata, s_ovalid); end
    #2;
    e_reset = 1'b0;
    #1;
    model_reset();
    total++; if (s_ovalid !== 1'b0 || s_odata !== 8'd0) begin bad++; $display("FAIL areset_now got=%0d/%0b exp=0/0", s_odata, s_ovalid); end
    @(negedge e_clk);
    e_reset = 1'b1;
    drive_cycle(1'b0, 0, 0, 1'b1, 0);
    total++; if (s_ovalid !== 1'b1 || s_odata !== 8'd0) begin bad++; $display("FAIL areset_cleared got=%0d/%0b exp=0/1", s_odata, s_ovalid); end
    drive_cycle(1'b1, 2, 0, 1'b0, 0);
    drive_cycle(1'b0, 0, 0, 1'b1, 0);
    total++; if (s_odata !== 8'd2) begin bad++; $display("FAIL areset_first_sample got=%0d exp=2", s_odata); end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_same_cycle();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acum_mch.md
Name: acum_mch

Overview:
- Parametrised multi-channel successor to the single-channel running accumulator.
- Accumulates unsigned input samples into NB_CH independent accumulators of width NB_ACC, each with a sticky overflow flag.
- Each channel is read out on request: a dump returns the accumulated value and atomically clears the channel.
- Sits between the sample source and the downstream consumer, one sample and at most one dump per clock.

Parameters:
- NB_INPUT, 4: width of input sample e_sum (unsigned).
- NB_ACC, 8: accumulator width per channel; must be ≥ NB_INPUT+1.
- NB_CH, 4: number of channels; ≥ 2.
- NB_SEL, 2: channel-index width; equals clog2(NB_CH).

Ports:
- e_clk, input, 1: clock, rising edge.
- e_reset, input, 1: asynchronous, active-low reset.
- e_sum, input, NB_INPUT: sample value.
- e_valid, input, 1: sample strobe; e_sum is added to channel e_ch when high.
- e_ch, input, NB_SEL: target channel for the sample.
- e_dump, input, 1: dump request for channel e_dch.
- e_dch, input, NB_SEL: channel to dump.
- s_odata, output, NB_ACC: dumped accumulator value.
- s_ovalid, output, 1: s_odata/s_overflow valid, single-cycle pulse.
- s_overflow, output, 1: sticky overflow flag of the dumped channel.
- s_ochan, output, NB_SEL: channel index of the current dump.

Behaviour:
- Reset (e_reset=0, async):
  - all accumulators and sticky flags = 0;
  - s_odata = 0, s_ovalid = 0, s_overflow = 0, s_ochan = 0.
  - Reset mid-operation discards all state immediately; first valid sample after deassertion is accepted on the next rising edge.
- Sample path, on e_valid=1: acc[e_ch] <= acc[e_ch] + e_sum, computed at NB_ACC+1 bits.
  - Carry-out set: wrap mode keeps the low NB_ACC bits; sticky ovf[e_ch] <= 1.
  - Sticky flag clears only on a dump of that channel or on reset.
- Dump path, on e_dump=1 (latency 1 cycle):
  - next edge: s_odata <= acc[e_dch], s_overflow <= ovf[e_dch], s_ochan <= e_dch, s_ovalid <= 1;
  - acc[e_dch] <= 0, ovf[e_dch] <= 0.
  - s_ovalid high for exactly one cycle per request; back-to-back dumps yield back-to-back pulses.
  - With no dump, s_ovalid = 0 and s_odata/s_overflow/s_ochan hold their last values.
- Simultaneous sample and dump, same channel:
  - dump reports the pre-sample value;
  - channel restarts with acc = e_sum; ovf = 0 (e_sum alone cannot overflow).
- Simultaneous sample and dump, different channels: both take effect independently in the same cycle.
- Out-of-range index (e_ch or e_dch ≥ NB_CH when NB_CH is not a power of two):
  - sample ignored;
  - dump returns s_odata = 0, s_overflow = 0, s_ovalid = 1.
- No internal FSM beyond per-channel registers; fully pipelined, one operation of each kind per clock.

Optional Feature:
- Macro ACUM_SAT_EN.
- Defined: saturating mode.
  - On carry-out, acc[e_ch] <= all-ones (2^NB_ACC−1) and ovf[e_ch] <= 1.
  - Further samples leave acc at all-ones until dumped.
- Undefined: wrap-around as described in Behaviour.

Test Plan (defaults NB_INPUT=4, NB_ACC=8, NB_CH=4):
- Reset then 10 samples of 5 on ch2, dump ch2 -> next cycle s_odata=50, s_ovalid=1 for one cycle, s_overflow=0, s_ochan=2; a second dump of ch2 -> s_odata=0.
- 18 samples of 15 on ch1, dump ch1:
  - wrap build -> s_odata=270 mod 256=14, s_overflow=1;
  - ACUM_SAT_EN build -> s_odata=255, s_overflow=1.
- Interleave samples 3 to ch0 and 7 to ch3 (4 each), dump ch0 then ch3 on consecutive cycles -> two consecutive pulses: 12 (ch0) then 28 (ch3).
- Accumulate 20 on ch1, then in one cycle e_valid=1 with e_sum=9 on ch1 and e_dump=1 on ch1 -> s_odata=20; a subsequent dump -> 9.
- Accumulate 40 on ch0, assert e_reset=0 between clock edges -> s_ovalid, s_odata drop to 0 immediately; after release a dump of ch0 -> s_odata=0.
